// File: rtl/seg7_scan.sv
// Two-digit multiplexed seven-segment scanner with anti-ghost blanking and frame-aligned updates.
// Optional brightness PWM is enabled by defining SEG7_DIM_EN, which adds the dim_i input.
module seg7_scan #(
  parameter int SCAN_DIV     = 25000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic [1:0] wr_dp,
  input  logic       blank_i,
`ifdef SEG7_DIM_EN
  input  logic [3:0] dim_i,
`endif
  output logic       wr_ack,
  output logic [7:0] SEG_o,
  output logic [1:0] COM_o
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          digit_q, digit_d;
  logic [7:0]    pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [1:0]    pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic          ack_q, ack_d;
  logic [7:0]    seg_q, seg_d;
  logic [1:0]    com_q, com_d;
  logic          wrap;
  logic [3:0]    nib;
`ifdef SEG7_DIM_EN
  logic [3:0]    pwm_q, pwm_d;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    wrap       = (cnt_q == CNT_LAST);
    cnt_d      = wrap ? '0 : cnt_q + 1'b1;
    digit_d    = wrap ? ~digit_q : digit_q;
    pend_val_d = wr_en ? wr_data : pend_val_q;
    pend_dp_d  = wr_en ? wr_dp : pend_dp_q;
    ack_d      = wr_en;
    // Frame boundary copies the pending value as it stood before this edge.
    act_val_d  = (wrap && digit_q) ? pend_val_q : act_val_q;
    act_dp_d   = (wrap && digit_q) ? pend_dp_q : act_dp_q;

    state_d = state_q;
    case (state_q)
      BLANK:   if (cnt_q == BLANK_LAST) state_d = DRIVE;
      DRIVE:   if (wrap) state_d = BLANK;
      default: state_d = BLANK;
    endcase

`ifdef SEG7_DIM_EN
    pwm_d = pwm_q + 4'd1;
`endif

    // Outputs are built from next-state values so they land on the same edge.
    nib   = digit_d ? act_val_d[7:4] : act_val_d[3:0];
    seg_d = 8'hFF;
    com_d = 2'b11;
    if (state_d == DRIVE && !blank_i) begin
      com_d = digit_d ? 2'b01 : 2'b10;
      seg_d = ~{act_dp_d[digit_d], hex7(nib)};
`ifdef SEG7_DIM_EN
      if (pwm_d > dim_i) seg_d = 8'hFF;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= BLANK;
      cnt_q      <= '0;
      digit_q    <= 1'b0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      ack_q      <= 1'b0;
      seg_q      <= 8'hFF;
      com_q      <= 2'b11;
`ifdef SEG7_DIM_EN
      pwm_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      ack_q      <= ack_d;
      seg_q      <= seg_d;
      com_q      <= com_d;
`ifdef SEG7_DIM_EN
      pwm_q      <= pwm_d;
`endif
    end
  end

  assign wr_ack = ack_q;
  assign SEG_o  = seg_q;
  assign COM_o  = com_q;

endmodule
